// File: rtl/s100_bus_exerciser.sv
// s100_bus_exerciser: S-100 bus cycle generator driving read/write cycles over a stepping address
//
// Ports:
//   pll0_2MHz      sole clock, all state updates on its rising edge
//   s100_RESET     asynchronous active-high reset
//   run            enables the prescaler and therefore new bus cycles
//   mode           address sequence: 00 up, 01 down, 10 walking-one, 11 hold
//   step_div       prescaler reload value (0 = tick every clock)
//   F_in_sdsb      status/address/data disable input
//   F_in_cdsb      control disable input
//   S100adr        address bus
//   s100_DO        data-out bus, loaded with the low address byte on write cycles
//   s100_pSYNC     T1 strobe (active-high)
//   s100_pSTVAL    T2 strobe (active-low)
//   s100_pDBIN     T3 read strobe (active-high)
//   s100_n_pWR     T3 write strobe (active-low)
//   s100_sMWRT     T3 write status (active-high)
//   sbcLEDS        inverted top address byte for active-low LEDs
//   F_*_oe         bus buffer enables
//   overrun        sticky: a prescaler tick arrived while a cycle was in progress
//   seg7, seg7_dp  active-low 7-segment display of mode plus a tick-toggled dot
//
// Build option: define S100_EXERCISER_SEG7_EN to drive the seven-segment display;
// without it the display outputs stay blank (all ones).
module s100_bus_exerciser #(
  parameter int ADDR_W = 20,
  parameter int PRE_W  = 16
) (
  input  logic              pll0_2MHz,
  input  logic              s100_RESET,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [PRE_W-1:0]  step_div,
  input  logic              F_in_sdsb,
  input  logic              F_in_cdsb,
  output logic [ADDR_W-1:0] S100adr,
  output logic [7:0]        s100_DO,
  output logic              s100_pSYNC,
  output logic              s100_pDBIN,
  output logic              s100_sMWRT,
  output logic              s100_pSTVAL,
  output logic              s100_n_pWR,
  output logic [7:0]        sbcLEDS,
  output logic              F_add_oe,
  output logic              F_bus_stat_oe,
  output logic              F_out_DO_oe,
  output logic              F_bus_ctl_oe,
  output logic              overrun,
  output logic [6:0]        seg7,
  output logic              seg7_dp
);
  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  state_t state, state_nx;
  logic [PRE_W-1:0] pre;
  logic [ADDR_W-1:0] adr_nx;
  logic tick, accept, wr, wr_next;
  assign tick   = run && pre == '0;
  assign accept = tick && state == IDLE;
  // walking-one reseeds with 1 when the address is zero so the pattern never dies
  always_comb
    adr_nx = mode == 2'b00 ? S100adr + ADDR_W'(1) :
             mode == 2'b01 ? S100adr - ADDR_W'(1) :
             mode == 2'b10 ? (S100adr == '0 ? ADDR_W'(1) : {S100adr[ADDR_W-2:0], S100adr[ADDR_W-1]}) :
             S100adr;
  always_comb begin
    state_nx    = state == IDLE ? (accept ? T1 : IDLE) : state == T1 ? T2 : state == T2 ? T3 : IDLE;
    s100_pSYNC  = state == T1;
    s100_pSTVAL = state != T2;
    s100_pDBIN  = state == T3 && !wr;
    s100_sMWRT  = state == T3 && wr;
    s100_n_pWR  = !(state == T3 && wr);
  end
  // wr is the type of the cycle in progress, wr_next the type of the one to come
  always_ff @(posedge pll0_2MHz or posedge s100_RESET)
    if (s100_RESET) begin
      state   <= IDLE;
      pre     <= '0;
      S100adr <= '0;
      wr      <= 1'b0;
      wr_next <= 1'b0;
      s100_DO <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (run) pre <= tick ? step_div : pre - PRE_W'(1);
      if (accept) begin
        S100adr <= adr_nx;
        wr      <= wr_next;
        wr_next <= !wr_next;
        if (wr_next) s100_DO <= adr_nx[7:0];
      end
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  assign sbcLEDS       = ~S100adr[ADDR_W-1 -: 8];
  assign F_add_oe      = !F_in_sdsb;
  assign F_bus_stat_oe = !F_in_sdsb;
  assign F_out_DO_oe   = !F_in_sdsb;
  assign F_bus_ctl_oe  = !F_in_cdsb;
`ifdef S100_EXERCISER_SEG7_EN
  logic dp;
  always_ff @(posedge pll0_2MHz or posedge s100_RESET)
    if (s100_RESET) dp <= 1'b1;
    else if (accept) dp <= !dp;
  // segment order g..a, active-low
  always_comb
    seg7 = mode == 2'd0 ? 7'b1000000 :
           mode == 2'd1 ? 7'b1111001 :
           mode == 2'd2 ? 7'b0100100 : 7'b0110000;
  assign seg7_dp = dp;
`else
  assign seg7    = 7'b1111111;
  assign seg7_dp = 1'b1;
`endif
endmodule

// File: tb/tb_s100_bus_exerciser.sv
// tb_s100_bus_exerciser: table, directed and randomized checks of s100_bus_exerciser against a behavioural model
module tb_s100_bus_exerciser;
  localparam int AW  = 20;
  localparam int PW  = 16;
  localparam int MOD = 1 << AW;
`ifdef S100_EXERCISER_SEG7_EN
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
`else
  localparam logic [6:0] S0 = 7'b1111111, S1 = 7'b1111111, S2 = 7'b1111111, S3 = 7'b1111111;
`endif
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, sdsb = 1'b0, cdsb = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [PW-1:0] step_div = '0;
  logic [AW-1:0] adr;
  logic [7:0] dout, leds;
  logic psync, pdbin, smwrt, pstval, npwr, add_oe, stat_oe, do_oe, ctl_oe, ovr, dp;
  logic [6:0] seg;
  int checks = 0, errors = 0;
  int m_adr, m_pre, m_pos, m_do;
  bit m_wr, m_wrnext, m_ovr, m_dp;

  s100_bus_exerciser #(.ADDR_W(AW), .PRE_W(PW)) dut (
    .pll0_2MHz(clk), .s100_RESET(rst), .run(run), .mode(mode), .step_div(step_div),
    .F_in_sdsb(sdsb), .F_in_cdsb(cdsb), .S100adr(adr), .s100_DO(dout),
    .s100_pSYNC(psync), .s100_pDBIN(pdbin), .s100_sMWRT(smwrt), .s100_pSTVAL(pstval),
    .s100_n_pWR(npwr), .sbcLEDS(leds), .F_add_oe(add_oe), .F_bus_stat_oe(stat_oe),
    .F_out_DO_oe(do_oe), .F_bus_ctl_oe(ctl_oe), .overrun(ovr), .seg7(seg), .seg7_dp(dp));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic sdsb, cdsb;
    logic [1:0] mode;
    logic e_oe, e_ctl;
    logic [6:0] e_seg;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(logic [1:0] m);
    return m == 2'd0 ? S0 : m == 2'd1 ? S1 : m == 2'd2 ? S2 : S3;
  endfunction

  task automatic model_reset();
    m_adr = 0; m_pre = 0; m_pos = 0; m_do = 0;
    m_wr = 0; m_wrnext = 0; m_ovr = 0; m_dp = 1;
  endtask

  // m_pos counts clocks into the current bus cycle: 0 idle, 1..3 = T1..T3
  task automatic model_update();
    bit tick;
    if (rst) begin
      model_reset();
      return;
    end
    tick = run && m_pre == 0;
    if (run) m_pre = tick ? int'(step_div) : m_pre - 1;
    if (tick && m_pos == 0) begin
      case (mode)
        2'd0: m_adr = (m_adr + 1) % MOD;
        2'd1: m_adr = (m_adr + MOD - 1) % MOD;
        2'd2: m_adr = m_adr == 0 ? 1 : ((m_adr * 2) % MOD) + (m_adr / (MOD / 2));
        default: ;
      endcase
      m_wr = m_wrnext;
      m_wrnext = !m_wrnext;
      if (m_wr) m_do = m_adr % 256;
`ifdef S100_EXERCISER_SEG7_EN
      m_dp = !m_dp;
`endif
      m_pos = 1;
    end else begin
      if (tick) m_ovr = 1;
      m_pos = m_pos == 0 ? 0 : (m_pos + 1) % 4;
    end
  endtask

  task automatic compare_all();
    chk("adr", 32'(adr), m_adr);
    chk("do", 32'(dout), m_do);
    chk("psync", 32'(psync), 32'(m_pos == 1));
    chk("pstval", 32'(pstval), 32'(m_pos != 2));
    chk("pdbin", 32'(pdbin), 32'(m_pos == 3 && !m_wr));
    chk("smwrt", 32'(smwrt), 32'(m_pos == 3 && m_wr));
    chk("npwr", 32'(npwr), 32'(!(m_pos == 3 && m_wr)));
    chk("leds", 32'(leds), (~(m_adr / 4096)) & 255);
    chk("overrun", 32'(ovr), 32'(m_ovr));
    chk("seg7", 32'(seg), 32'(seg_exp(mode)));
    chk("seg7_dp", 32'(dp), 32'(m_dp));
    chk("sts_oe", {add_oe, stat_oe, do_oe, ctl_oe}, {{3{!sdsb}}, !cdsb});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until_sync(string name);
    for (int i = 0; i < 64; i++) begin
      step();
      if (psync) return;
    end
    chk({name, "_sync_timeout"}, 32'(psync), 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, S2};
    tbl[1] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, S0};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1, S1};
    tbl[3] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, S3};
    model_reset();
    #3;
    compare_all();
    for (int i = 0; i < 4; i++) begin
      sdsb = tbl[i].sdsb; cdsb = tbl[i].cdsb; mode = tbl[i].mode;
      #1;
      chk("tbl_add_oe", 32'(add_oe), 32'(tbl[i].e_oe));
      chk("tbl_stat_oe", 32'(stat_oe), 32'(tbl[i].e_oe));
      chk("tbl_do_oe", 32'(do_oe), 32'(tbl[i].e_oe));
      chk("tbl_ctl_oe", 32'(ctl_oe), 32'(tbl[i].e_ctl));
      chk("tbl_seg7", 32'(seg), 32'(tbl[i].e_seg));
    end
    sdsb = 1'b0; cdsb = 1'b0;
    // up count from reset, tick every clock
    do_reset();
    mode = 2'd0; step_div = '0; run = 1'b1; rst = 1'b0;
    step();
    chk("up_first_adr", 32'(adr), 1);
    chk("up_first_sync", 32'(psync), 1);
    step();
    chk("up_overrun", 32'(ovr), 1);
    run_until_sync("up2");
    chk("up_adr2", 32'(adr), 2);
    run_until_sync("up3");
    chk("up_adr3", 32'(adr), 3);
    // down count wraps from 0
    do_reset();
    mode = 2'd1; step_div = PW'(3); rst = 1'b0;
    step();
    chk("down_wrap", 32'(adr), 32'h000FFFFF);
    step(); step();
    chk("down_pdbin", 32'(pdbin), 1);
    chk("down_npwr", 32'(npwr), 1);
    // walking one, including top-bit rotation back to bit 0
    do_reset();
    mode = 2'd2; step_div = '0; rst = 1'b0;
    step();
    chk("walk_from0", 32'(adr), 1);
    for (int i = 0; i < 19; i++) run_until_sync("walk");
    chk("walk_top", 32'(adr), 32'h00080000);
    run_until_sync("walk_rot");
    chk("walk_rot", 32'(adr), 1);
    // write cycle carrying 0xA5
    do_reset();
    mode = 2'd0; rst = 1'b0;
    step();
    for (int i = 1; i < 165; i++) run_until_sync("a5");
    chk("a5_read_adr", 32'(adr), 32'hA5);
    mode = 2'd3;
    run_until_sync("a5w");
    chk("a5_adr", 32'(adr), 32'hA5);
    chk("a5_do", 32'(dout), 32'hA5);
    chk("a5_leds", 32'(leds), 32'hFF);
    chk("a5_t1_npwr", 32'(npwr), 1);
    step();
    chk("a5_t2_smwrt", 32'(smwrt), 0);
    step();
    chk("a5_t3_npwr", 32'(npwr), 0);
    chk("a5_t3_smwrt", 32'(smwrt), 1);
    step();
    chk("a5_idle_npwr", 32'(npwr), 1);
    chk("a5_idle_smwrt", 32'(smwrt), 0);
    // reset in T2 aborts at once
    do_reset();
    mode = 2'd0; rst = 1'b0;
    step(); step();
    chk("abort_t2", 32'(pstval), 0);
    rst = 1'b1;
    #1;
    chk("abort_pstval", 32'(pstval), 1);
    chk("abort_psync", 32'(psync), 0);
    chk("abort_adr", 32'(adr), 0);
    step();
    rst = 1'b0;
    // run dropped in T1 finishes the cycle then stays idle
    step();
    chk("drop_t1", 32'(psync), 1);
    run = 1'b0;
    step();
    chk("drop_t2", 32'(pstval), 0);
    step();
    chk("drop_t3", 32'(pdbin), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("drop_nosync", 32'(psync), 0);
    end
    // randomized
    do_reset();
    run = 1'b1; rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      run = $urandom_range(7) != 0;
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) step_div = PW'($urandom_range(5));
      sdsb = 1'($urandom_range(1));
      cdsb = 1'($urandom_range(1));
      rst = $urandom_range(499) == 0;
      step();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
